// File: rtl/des_varint_field.sv
// des_varint_field: parses one protobuf varint field from a wire buffer in DRAM
// and stores the decoded (optionally zigzag) value little-endian into an object.
`default_nettype none

module des_varint_field #(
    parameter int MAX_VARINT_BYTES = 10,
    parameter int MAX_TAG_BYTES    = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_entry_valid,
    input  logic [28:0]  i_field_num,
    input  logic [3:0]   i_field_size,
    input  logic         i_zigzag,
    input  logic [31:0]  i_obj_offset,
    input  logic [63:0]  i_obj_base,
    input  logic [63:0]  i_wire_ptr,
    input  logic [63:0]  i_wire_end,
    output logic         o_ready,
    output logic         o_done,
    output logic         o_match,
    output logic         o_err,
    output logic [63:0]  o_next_ptr,
    output logic [7:0]   o_dram_en,
    output logic         o_dram_rdwr,
    output logic [511:0] o_dram_addr,
    output logic [63:0]  o_dram_data_out,
    input  logic [63:0]  i_dram_data_in,
    input  logic [7:0]   i_dram_valid
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TAG_FETCH = 3'd1,
        S_TAG_DEC   = 3'd2,
        S_VAL_FETCH = 3'd3,
        S_VAL_DEC   = 3'd4,
        S_WRITE     = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    state_t         r_state, w_state;
    logic [28:0]    r_field_num, w_field_num;
    logic [3:0]     r_size, w_size;
    logic           r_zz, w_zz;
    logic [63:0]    r_obj_addr, w_obj_addr;
    logic [63:0]    r_wire_ptr, w_wire_ptr;
    logic [63:0]    r_wire_end, w_wire_end;
    logic [63:0]    r_cur_ptr, w_cur_ptr;
    logic           r_active, w_active;
    logic [7:0]     r_got, w_got;
    logic [7:0]     r_win, w_win;
    logic [63:0]    r_buf, w_buf;
    logic [63:0]    r_acc, w_acc;
    logic [4:0]     r_nbytes, w_nbytes;
    logic           r_match, w_match;
    logic           r_err, w_err;
    logic [63:0]    r_next_ptr, w_next_ptr;
    logic [7:0]     r_dram_en, w_dram_en;
    logic           r_rdwr, w_rdwr;
    logic [511:0]   r_addr, w_addr;
    logic [63:0]    r_wdata, w_wdata;

    logic [7:0]     w_lane_en;
    logic [7:0]     w_got_all;
    logic [63:0]    w_dec_acc;
    logic [4:0]     w_dec_cnt;
    logic [4:0]     w_dec_max;
    logic [3:0]     w_dec_used;
    logic           w_dec_term;
    logic           w_dec_over;
    logic           w_stop;
    logic [6:0]     w_shift;
    logic [63:0]    w_zz_val;
    logic           w_size_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_field_num <= '0;
            r_size      <= '0;
            r_zz        <= 1'b0;
            r_obj_addr  <= '0;
            r_wire_ptr  <= '0;
            r_wire_end  <= '0;
            r_cur_ptr   <= '0;
            r_active    <= 1'b0;
            r_got       <= '0;
            r_win       <= '0;
            r_buf       <= '0;
            r_acc       <= '0;
            r_nbytes    <= '0;
            r_match     <= 1'b0;
            r_err       <= 1'b0;
            r_next_ptr  <= '0;
            r_dram_en   <= '0;
            r_rdwr      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_field_num <= w_field_num;
            r_size      <= w_size;
            r_zz        <= w_zz;
            r_obj_addr  <= w_obj_addr;
            r_wire_ptr  <= w_wire_ptr;
            r_wire_end  <= w_wire_end;
            r_cur_ptr   <= w_cur_ptr;
            r_active    <= w_active;
            r_got       <= w_got;
            r_win       <= w_win;
            r_buf       <= w_buf;
            r_acc       <= w_acc;
            r_nbytes    <= w_nbytes;
            r_match     <= w_match;
            r_err       <= w_err;
            r_next_ptr  <= w_next_ptr;
            r_dram_en   <= w_dram_en;
            r_rdwr      <= w_rdwr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_field_num = r_field_num;
        w_size      = r_size;
        w_zz        = r_zz;
        w_obj_addr  = r_obj_addr;
        w_wire_ptr  = r_wire_ptr;
        w_wire_end  = r_wire_end;
        w_cur_ptr   = r_cur_ptr;
        w_active    = r_active;
        w_got       = r_got;
        w_win       = r_win;
        w_buf       = r_buf;
        w_acc       = r_acc;
        w_nbytes    = r_nbytes;
        w_match     = r_match;
        w_err       = r_err;
        w_next_ptr  = r_next_ptr;
        w_dram_en   = r_dram_en;
        w_rdwr      = r_rdwr;
        w_addr      = r_addr;
        w_wdata     = r_wdata;

        w_lane_en = '0;
        for (int i = 0; i < 8; i++) begin
            if ((r_cur_ptr + 64'(i)) < r_wire_end) w_lane_en[i] = 1'b1;
        end
        w_got_all = r_got | (i_dram_valid & r_dram_en);
        w_size_ok = (r_size == 4'd1) || (r_size == 4'd2) ||
                    (r_size == 4'd4) || (r_size == 4'd8);

        // Scan the fetched window in lane order, 7 payload bits per byte.
        w_dec_acc  = r_acc;
        w_dec_cnt  = r_nbytes;
        w_dec_max  = (r_state == S_TAG_DEC) ? 5'(MAX_TAG_BYTES) : 5'(MAX_VARINT_BYTES);
        w_dec_used = '0;
        w_dec_term = 1'b0;
        w_dec_over = 1'b0;
        w_stop     = 1'b0;
        w_shift    = '0;
        for (int i = 0; i < 8; i++) begin
            if (!w_stop) begin
                if (!r_win[i]) begin
                    w_stop = 1'b1;
                end else if (w_dec_cnt >= w_dec_max) begin
                    w_dec_over = 1'b1;
                    w_stop     = 1'b1;
                end else begin
                    w_shift = 7'd7 * {2'b00, w_dec_cnt};
                    if (w_shift < 7'd64)
                        w_dec_acc = w_dec_acc | ({57'd0, r_buf[8*i +: 7]} << w_shift[5:0]);
                    w_dec_cnt  = w_dec_cnt + 5'd1;
                    w_dec_used = w_dec_used + 4'd1;
                    if (!r_buf[8*i+7]) begin
                        w_dec_term = 1'b1;
                        w_stop     = 1'b1;
                    end
                end
            end
        end
        w_zz_val = (w_dec_acc >> 1) ^ {64{w_dec_acc[0]}};

        case (r_state)
            S_IDLE: begin
                if (i_en && i_entry_valid) begin
                    w_field_num = i_field_num;
                    w_size      = i_field_size;
                    w_zz        = i_zigzag;
                    w_obj_addr  = i_obj_base + {32'd0, i_obj_offset};
                    w_wire_ptr  = i_wire_ptr;
                    w_wire_end  = i_wire_end;
                    w_cur_ptr   = i_wire_ptr;
                    w_acc       = '0;
                    w_nbytes    = '0;
                    w_active    = 1'b0;
                    w_match     = 1'b0;
                    w_err       = 1'b0;
                    w_next_ptr  = '0;
                    w_state     = S_TAG_FETCH;
                end
            end
            S_TAG_FETCH, S_VAL_FETCH: begin
                if (!r_active) begin
                    if (w_lane_en == 8'd0) begin
                        w_err      = 1'b1;
                        w_next_ptr = r_wire_ptr;
                        w_state    = S_FIN;
                    end else begin
                        w_dram_en = w_lane_en;
                        w_rdwr    = 1'b0;
                        w_win     = w_lane_en;
                        w_got     = '0;
                        w_active  = 1'b1;
                        for (int i = 0; i < 8; i++) w_addr[64*i +: 64] = r_cur_ptr + 64'(i);
                    end
                end else begin
                    // Lanes may complete on different cycles; capture each as it arrives.
                    w_got = w_got_all;
                    for (int i = 0; i < 8; i++) begin
                        if (i_dram_valid[i] && r_dram_en[i]) w_buf[8*i +: 8] = i_dram_data_in[8*i +: 8];
                    end
                    if (w_got_all == r_dram_en) begin
                        w_dram_en = '0;
                        w_active  = 1'b0;
                        w_state   = (r_state == S_TAG_FETCH) ? S_TAG_DEC : S_VAL_DEC;
                    end
                end
            end
            S_TAG_DEC, S_VAL_DEC: begin
                w_acc     = w_dec_acc;
                w_nbytes  = w_dec_cnt;
                w_cur_ptr = r_cur_ptr + {60'd0, w_dec_used};
                if (w_dec_over || (!w_dec_term && r_win != 8'hFF)) begin
                    w_err      = 1'b1;
                    w_next_ptr = r_wire_ptr;
                    w_state    = S_FIN;
                end else if (!w_dec_term) begin
                    w_state = (r_state == S_TAG_DEC) ? S_TAG_FETCH : S_VAL_FETCH;
                end else if (r_state == S_TAG_DEC) begin
                    if (w_dec_acc[2:0] == 3'd0 && w_dec_acc[31:3] == r_field_num) begin
                        if (w_size_ok) begin
                            w_acc    = '0;
                            w_nbytes = '0;
                            w_state  = S_VAL_FETCH;
                        end else begin
                            w_err      = 1'b1;
                            w_next_ptr = r_wire_ptr;
                            w_state    = S_FIN;
                        end
                    end else begin
                        w_next_ptr = r_wire_ptr;
                        w_state    = S_FIN;
                    end
                end else begin
                    w_acc   = r_zz ? w_zz_val : w_dec_acc;
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!r_active) begin
                    w_rdwr   = 1'b1;
                    w_got    = '0;
                    w_active = 1'b1;
                    w_wdata  = r_acc;
                    for (int i = 0; i < 8; i++) begin
                        w_dram_en[i]       = (4'(i) < r_size);
                        w_addr[64*i +: 64] = r_obj_addr + 64'(i);
                    end
                end else begin
                    w_got = w_got_all;
                    if (w_got_all == r_dram_en) begin
                        w_dram_en  = '0;
                        w_rdwr     = 1'b0;
                        w_active   = 1'b0;
                        w_match    = 1'b1;
                        w_next_ptr = r_cur_ptr;
                        w_state    = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_ready         = (r_state == S_IDLE);
    assign o_done          = (r_state == S_FIN);
    assign o_match         = r_match;
    assign o_err           = r_err;
    assign o_next_ptr      = r_next_ptr;
    assign o_dram_en       = r_dram_en;
    assign o_dram_rdwr     = r_rdwr;
    assign o_dram_addr     = r_addr;
    assign o_dram_data_out = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_des_varint_field.sv
// tb_des_varint_field: directed checks of des_varint_field against a lane-latency DRAM model.
`default_nettype none

module tb_des_varint_field;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         entry_valid = 1'b0;
    logic [28:0]  field_num = '0;
    logic [3:0]   field_size = '0;
    logic         zigzag = 1'b0;
    logic [31:0]  obj_offset = '0;
    logic [63:0]  obj_base = '0;
    logic [63:0]  wire_ptr = '0;
    logic [63:0]  wire_end = '0;
    logic         ready, done, match, err;
    logic [63:0]  next_ptr;
    logic [7:0]   dram_en;
    logic         dram_rdwr;
    logic [511:0] dram_addr;
    logic [63:0]  dram_data_out;
    logic [63:0]  dram_data_in = '0;
    logic [7:0]   dram_valid = '0;

    des_varint_field dut (
        .clk(clk), .reset(reset), .i_en(en), .i_entry_valid(entry_valid),
        .i_field_num(field_num), .i_field_size(field_size), .i_zigzag(zigzag),
        .i_obj_offset(obj_offset), .i_obj_base(obj_base), .i_wire_ptr(wire_ptr),
        .i_wire_end(wire_end), .o_ready(ready), .o_done(done), .o_match(match),
        .o_err(err), .o_next_ptr(next_ptr), .o_dram_en(dram_en), .o_dram_rdwr(dram_rdwr),
        .o_dram_addr(dram_addr), .o_dram_data_out(dram_data_out),
        .i_dram_data_in(dram_data_in), .i_dram_valid(dram_valid)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:4095];
    int          lane_lat [0:7];
    logic        clr = 1'b0;
    logic [7:0]  wr_data [0:255];
    logic        wr_flag [0:255];
    int          wr_lanes = 0;
    int          wr_starts = 0;
    int          rd_starts = 0;
    int          lat_cnt [0:7];
    logic [7:0]  lane_done = '0;
    logic        en_prev = 1'b0;

    int total = 0;
    int bad = 0;
    logic        got_done;
    logic        res_match, res_err;
    logic [63:0] res_next;

    // DRAM model: each lane answers after its own latency, one valid pulse per access.
    always @(posedge clk) begin
        int n;
        n = 0;
        en_prev <= |dram_en;
        if (clr) begin
            for (int a = 0; a < 256; a++) begin
                wr_flag[a] <= 1'b0;
                wr_data[a] <= 8'h00;
            end
            wr_lanes  <= 0;
            wr_starts <= 0;
            rd_starts <= 0;
        end else if (dram_en != 8'd0 && !en_prev) begin
            if (dram_rdwr) wr_starts <= wr_starts + 1;
            else rd_starts <= rd_starts + 1;
        end
        for (int i = 0; i < 8; i++) begin
            if (dram_en[i] && !lane_done[i]) begin
                if (lat_cnt[i] >= lane_lat[i]) begin
                    dram_valid[i] <= 1'b1;
                    lane_done[i]  <= 1'b1;
                    if (dram_rdwr) begin
                        wr_data[dram_addr[64*i +: 8]] <= dram_data_out[8*i +: 8];
                        wr_flag[dram_addr[64*i +: 8]] <= 1'b1;
                        n = n + 1;
                    end else begin
                        dram_data_in[8*i +: 8] <= mem[dram_addr[64*i +: 12]];
                    end
                end else begin
                    lat_cnt[i] <= lat_cnt[i] + 1;
                end
            end else begin
                dram_valid[i] <= 1'b0;
                if (!dram_en[i]) begin
                    lane_done[i] <= 1'b0;
                    lat_cnt[i]   <= 0;
                end
            end
        end
        if (!clr) wr_lanes <= wr_lanes + n;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int a = 12'h300; a < 12'h340; a++) mem[a] = 8'h00;
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic run_op(input logic [28:0] fn, input logic [3:0] sz, input logic zz,
                          input logic [63:0] wend);
        @(negedge clk);
        field_num = fn; field_size = sz; zigzag = zz;
        obj_base = 64'h40; obj_offset = 32'h10; wire_ptr = 64'h300; wire_end = wend;
        en = 1'b1; entry_valid = 1'b1;
        @(negedge clk);
        en = 1'b0; entry_valid = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
        res_match = match; res_err = err; res_next = next_ptr;
        chk("done_seen", {63'd0, got_done}, 64'd1);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("ready_after", {63'd0, ready}, 64'd1);
    endtask

    task automatic check_basic(input string pfx);
        chk({pfx, "_match"}, {63'd0, res_match}, 64'd1);
        chk({pfx, "_err"}, {63'd0, res_err}, 64'd0);
        chk({pfx, "_next"}, res_next, 64'h303);
        chk({pfx, "_byte0"}, {56'd0, wr_data[8'h50]}, 64'h96);
        for (int b = 1; b < 8; b++) chk({pfx, "_byteN"}, {56'd0, wr_data[8'h50 + b]}, 64'h00);
        chk({pfx, "_lanes"}, 64'(wr_lanes), 64'd8);
        chk({pfx, "_wr_starts"}, 64'(wr_starts), 64'd1);
    endtask

    task automatic load_basic();
        mem[12'h300] = 8'h08; mem[12'h301] = 8'h96; mem[12'h302] = 8'h01;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) lane_lat[i] = 0;
        for (int i = 0; i < 8; i++) lat_cnt[i] = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dram_en", {56'd0, dram_en}, 64'd0);
        chk("rst_match_err", {62'd0, match, err}, 64'd0);
        chk("rst_next_ptr", next_ptr, 64'd0);
        reset = 1'b1;

        clear_all(); load_basic();
        run_op(29'd1, 4'd8, 1'b0, 64'h400);
        check_basic("basic");

        clear_all();
        mem[12'h300] = 8'h10; mem[12'h301] = 8'h05;
        run_op(29'd1, 4'd8, 1'b0, 64'h400);
        chk("mis_match", {63'd0, res_match}, 64'd0);
        chk("mis_err", {63'd0, res_err}, 64'd0);
        chk("mis_next", res_next, 64'h300);
        chk("mis_no_write", 64'(wr_lanes), 64'd0);

        clear_all();
        mem[12'h300] = 8'h08; mem[12'h301] = 8'h03;
        run_op(29'd1, 4'd4, 1'b1, 64'h400);
        chk("zz_match", {63'd0, res_match}, 64'd1);
        chk("zz_next", res_next, 64'h302);
        chk("zz_bytes", {32'd0, wr_data[8'h53], wr_data[8'h52], wr_data[8'h51], wr_data[8'h50]},
            64'hFFFF_FFFE);
        chk("zz_untouched", {60'd0, wr_flag[8'h54], wr_flag[8'h55], wr_flag[8'h56], wr_flag[8'h57]}, 64'd0);

        clear_all();
        mem[12'h300] = 8'h08;
        for (int a = 12'h301; a < 12'h30A; a++) mem[a] = 8'hFF;
        mem[12'h30A] = 8'h01;
        run_op(29'd1, 4'd8, 1'b0, 64'h400);
        chk("mw_match", {63'd0, res_match}, 64'd1);
        chk("mw_next", res_next, 64'h30B);
        chk("mw_value", {wr_data[8'h57], wr_data[8'h56], wr_data[8'h55], wr_data[8'h54],
                         wr_data[8'h53], wr_data[8'h52], wr_data[8'h51], wr_data[8'h50]},
            64'hFFFF_FFFF_FFFF_FFFF);
        chk("mw_val_fetches", {63'd0, rd_starts >= 3}, 64'd1);

        clear_all();
        mem[12'h300] = 8'h08; mem[12'h301] = 8'h96;
        run_op(29'd1, 4'd8, 1'b0, 64'h302);
        chk("trunc_err", {63'd0, res_err}, 64'd1);
        chk("trunc_match", {63'd0, res_match}, 64'd0);
        chk("trunc_next", res_next, 64'h300);
        chk("trunc_no_write", 64'(wr_lanes), 64'd0);

        clear_all();
        mem[12'h300] = 8'h08;
        for (int a = 12'h301; a < 12'h30C; a++) mem[a] = 8'hFF;
        run_op(29'd1, 4'd8, 1'b0, 64'h400);
        chk("long_err", {63'd0, res_err}, 64'd1);
        chk("long_no_write", 64'(wr_lanes), 64'd0);

        clear_all(); load_basic();
        run_op(29'd1, 4'd3, 1'b0, 64'h400);
        chk("size_err", {63'd0, res_err}, 64'd1);
        chk("size_no_write", 64'(wr_lanes), 64'd0);

        // Reset while the value fetch is outstanding.
        clear_all(); load_basic();
        for (int i = 0; i < 8; i++) lane_lat[i] = 30;
        @(negedge clk);
        field_num = 29'd1; field_size = 4'd8; zigzag = 1'b0;
        obj_base = 64'h40; obj_offset = 32'h10; wire_ptr = 64'h300; wire_end = 64'h400;
        en = 1'b1; entry_valid = 1'b1;
        @(negedge clk);
        en = 1'b0; entry_valid = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 500 && !got_done; c++) begin
            if (dram_en[0] && !dram_rdwr && dram_addr[63:0] == 64'h301) got_done = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_reached", {63'd0, got_done}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {63'd0, ready}, 64'd1);
        chk("rst_mid_dram_en", {56'd0, dram_en}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) lane_lat[i] = 0;
        repeat (2) @(negedge clk);
        clear_all(); load_basic();
        run_op(29'd1, 4'd8, 1'b0, 64'h400);
        check_basic("post_rst");

        clear_all(); load_basic();
        lane_lat[0] = 3; lane_lat[1] = 0; lane_lat[2] = 5; lane_lat[3] = 1;
        lane_lat[4] = 7; lane_lat[5] = 2; lane_lat[6] = 4; lane_lat[7] = 6;
        run_op(29'd1, 4'd8, 1'b0, 64'h400);
        check_basic("stagger");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/des_varint_field.md
Name: des_varint_field

Overview:
- Deserializer counterpart of the serialization datapath: parses one protobuf varint field from the wire buffer in DRAM and stores the decoded value into the C++ object in DRAM.
- Per table entry: fetches wire bytes, decodes the tag, and checks field number and wire type.
- On a tag match, decodes the varint value, optionally zigzag-decodes it, and writes 1/2/4/8 bytes little-endian at obj_base+obj_offset.
- Sits beside the serializer on the same 8-lane DRAM port. The parent deserializer issues one entry per tag.

Parameters:
MAX_VARINT_BYTES, 10, maximum value varint length before err
MAX_TAG_BYTES, 5, maximum tag varint length before err

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
en  in  1  start request; sampled in IDLE together with entry_valid
entry_valid  in  1  entry fields below are valid
field_num  in  29  expected protobuf field number
field_size  in  4  bytes to store: 1, 2, 4 or 8 (other values -> err)
zigzag  in  1  1 = sint field, apply zigzag decode
obj_offset  in  32  byte offset of the member inside the object
obj_base  in  64  object base address
wire_ptr  in  64  address of the first tag byte
wire_end  in  64  first address past the wire buffer
ready  out  1  1 in IDLE only
done  out  1  one-cycle pulse when the operation completes
match  out  1  valid with done: tag matched and value stored
err  out  1  valid with done: truncation, overlong varint or bad size
next_ptr  out  64  valid with done: address after the value on match; wire_ptr otherwise
dram_en  out  8  per-lane enable
dram_rdwr  out  1  0 = read, 1 = write
dram_addr  out  8x64  per-lane byte address
dram_data_out  out  8x8  per-lane write data
dram_data_in  in  8x8  per-lane read data
dram_valid  in  8  per-lane completion

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; ready=1.
  - done, match, err, dram_en, dram_rdwr = 0; next_ptr=0; dram_addr and dram_data_out = 0.
  - A reset mid-operation abandons any DRAM access immediately; dram_en drops on the next edge.
- States: IDLE, TAG_FETCH, TAG_DEC, VAL_FETCH, VAL_DEC, WRITE, FIN.
- IDLE:
  - en && entry_valid latches all entry inputs; cur_ptr=wire_ptr; go to TAG_FETCH; ready=0.
  - Inputs are don't-care after latch.
- Fetch states (TAG_FETCH and VAL_FETCH):
  - Lane i reads cur_ptr+i, enabled only if cur_ptr+i < wire_end.
  - If no lane is enabled, set err and go to FIN.
  - en, addr and rdwr are held until every enabled lane has shown dram_valid. A lane's valid is recorded when seen, so lanes need not complete in the same cycle.
  - On completion, dram_en drops for at least one cycle; go to the decode state.
- Varint decode (TAG_DEC and VAL_DEC):
  - Bytes are consumed in lane order, 7 bits each, LSB group first.
  - Accumulator: 35 bits for the tag, 64 bits for the value; bits beyond 64 are dropped.
  - A byte with MSB=0 terminates the varint; cur_ptr advances past it.
  - If the window is exhausted without a terminator: cur_ptr += bytes consumed; refetch (same state family) and continue accumulating.
  - Byte count > MAX_TAG_BYTES (tag) or > MAX_VARINT_BYTES (value) -> err.
  - A fetch that returns fewer lanes than needed, with cur_ptr reaching wire_end before a terminator -> err.
- Tag check:
  - tag[2:0]==0 and tag[31:3]==field_num -> VAL_FETCH.
  - Otherwise -> FIN with match=0, err=0, next_ptr=wire_ptr.
  - field_size not in {1,2,4,8} -> err, checked at the tag match.
- Zigzag: if zigzag, value = (v>>1) ^ -(v[0]).
- WRITE:
  - Single access: rdwr=1; lanes 0..field_size-1 enabled.
  - Lane i addr = obj_base+obj_offset+i (64-bit wrap); data = value byte i.
  - The value is truncated to field_size bytes.
  - Held until all enabled lanes are valid, then go to FIN with match=1 and next_ptr=cur_ptr.
- FIN:
  - done=1 for exactly one cycle; match, err and next_ptr are held until the next start.
  - Return to IDLE; ready=1 the following cycle.
- On err: no write is issued; match=0; next_ptr=wire_ptr.
- en held high across done does not restart until ready is observed with en sampled in IDLE. The next start may occur at the earliest one cycle after done.

Test Plan:
- Basic match:
  - Stimulus: wire 0x300 = 08 96 01; field_num=1, size=8, obj_base=0x40, obj_offset=0x10, wire_end=0x400.
  - Required: mem[0x50..0x57] = 96 00 00 00 00 00 00 00; match=1; next_ptr=0x303; exactly one write access.
- Mismatch:
  - Stimulus: wire 0x300 = 10 05 (field 2); field_num=1.
  - Required: done with match=0, err=0, next_ptr=0x300; no write lanes ever enabled.
- Zigzag with truncation:
  - Stimulus: wire 08 03; zigzag=1, size=4.
  - Required: object bytes FE FF FF FF; bytes +4..+7 untouched; next_ptr=0x302.
- Multi-window varint:
  - Stimulus: wire 08 FF FF FF FF FF FF FF FF FF 01.
  - Required: at least two value fetches; value 0xFFFFFFFFFFFFFFFF stored with size=8; next_ptr=0x30B.
- Truncation:
  - Stimulus: wire 08 96; wire_end=0x302.
  - Required: err=1, match=0, no write.
  - Stimulus: 11 bytes of FF after the tag.
  - Required: err=1.
- Reset and DRAM latency:
  - Stimulus: reset=0 asserted during VAL_FETCH.
  - Required: next cycle ready=1, dram_en=0, done=0; a subsequent basic-match run passes.
  - Stimulus: staggered per-lane dram_valid.
  - Required: identical results to the basic-match run.
